// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared encodings for the memory stage
package memory_stage_pkg;
  localparam logic [1:0] IT_ALU   = 2'd0;
  localparam logic [1:0] IT_LOAD  = 2'd1;
  localparam logic [1:0] IT_STORE = 2'd2;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
endpackage

// File: rtl/memory_stage_align.sv
// mem_align: fault check, load lane extract/extend, store byte enables and lane shift
module mem_align
  import memory_stage_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           ofs_i,
  input  logic                 store_i,
  input  logic [WORD_SIZE-1:0] s2_i,
  input  logic [WORD_SIZE-1:0] rdata_i,
  output logic                 fault_o,
  output logic [3:0]           be_o,
  output logic [WORD_SIZE-1:0] wdata_o,
  output logic [WORD_SIZE-1:0] load_o
);
  logic                 undef_q_n;
  logic                 misal;
  logic [WORD_SIZE-1:0] sh;
  // funct3[1:0] encodes access size; shift by the byte lane for both directions
  always_comb begin
    undef_q_n = store_i ? !(funct3_i inside {F3_SB, F3_SH, F3_SW})
                        : !(funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    misal = funct3_i[1:0] == 2'b01 ? ofs_i[0] : funct3_i[1:0] == 2'b10 ? |ofs_i : 1'b0;
    fault_o = undef_q_n | misal;
    be_o = (funct3_i[1:0] == 2'b00 ? 4'b0001 : funct3_i[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << ofs_i;
    wdata_o = s2_i << {ofs_i, 3'b000};
    sh = rdata_i >> {ofs_i, 3'b000};
    load_o = funct3_i == F3_LB  ? {{(WORD_SIZE-8){sh[7]}}, sh[7:0]} :
             funct3_i == F3_LH  ? {{(WORD_SIZE-16){sh[15]}}, sh[15:0]} :
             funct3_i == F3_LBU ? {{(WORD_SIZE-8){1'b0}}, sh[7:0]} :
             funct3_i == F3_LHU ? {{(WORD_SIZE-16){1'b0}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: M stage FSM driving the data cache handshake and the writeback register
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int WORD_SIZE       = 32,
  parameter int INSTR_TYPE_SZ   = 2,
  parameter int ROB_ENTRY_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
  input  logic [WORD_SIZE-1:0]       pc,
  input  logic [2:0]                 funct3,
  input  logic [WORD_SIZE-1:0]       aluResult,
  input  logic [WORD_SIZE-1:0]       s2,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  input  logic                       valid,
  output logic                       stall_out,
  output logic                       dc_req_valid,
  input  logic                       dc_req_ready,
  output logic                       dc_we,
  output logic [WORD_SIZE-1:0]       dc_addr,
  output logic [3:0]                 dc_be,
  output logic [WORD_SIZE-1:0]       dc_wdata,
  input  logic                       dc_resp_valid,
  input  logic [WORD_SIZE-1:0]       dc_resp_data,
  output logic                       wb_valid,
  output logic [WORD_SIZE-1:0]       wb_pc,
  output logic [WORD_SIZE-1:0]       wb_result,
  output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
  output logic                       wb_exception
);
  state_e                     state_q, state_d;
  logic                       is_load, is_store, is_mem, fault, go;
  logic [WORD_SIZE-1:0]       load_data;
  logic                       wb_valid_q, wb_valid_d, wb_exception_q, wb_exception_d;
  logic [WORD_SIZE-1:0]       wb_result_q, wb_result_d, wb_pc_q;
  logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id_q;
  assign is_load  = instruction_type == INSTR_TYPE_SZ'(IT_LOAD);
  assign is_store = instruction_type == INSTR_TYPE_SZ'(IT_STORE);
  assign is_mem   = is_load | is_store;
  assign go       = valid & is_mem & ~fault;
  assign dc_we    = is_store;
  assign dc_addr  = {aluResult[WORD_SIZE-1:2], 2'b00};
  assign wb_valid     = wb_valid_q;
  assign wb_pc        = wb_pc_q;
  assign wb_result    = wb_result_q;
  assign wb_rob_id    = wb_rob_id_q;
  assign wb_exception = wb_exception_q;
  mem_align #(.WORD_SIZE(WORD_SIZE)) u_align (
    .funct3_i(funct3),
    .ofs_i   (aluResult[1:0]),
    .store_i (is_store),
    .s2_i    (s2),
    .rdata_i (dc_resp_data),
    .fault_o (fault),
    .be_o    (dc_be),
    .wdata_o (dc_wdata),
    .load_o  (load_data)
  );
  // Request fields come straight from the held EX/M register, so they stay stable while stalled
  always_comb begin
    state_d        = state_q;
    dc_req_valid   = 1'b0;
    stall_out      = 1'b0;
    wb_valid_d     = 1'b0;
    wb_exception_d = 1'b0;
    wb_result_d    = aluResult;
    if (state_q == S_IDLE) begin
      dc_req_valid   = go;
      stall_out      = go;
      wb_valid_d     = valid & ~go;
      wb_exception_d = is_mem & fault;
      if (go) state_d = dc_req_ready ? S_WAIT : S_REQ;
    end else if (state_q == S_REQ) begin
      dc_req_valid = 1'b1;
      stall_out    = 1'b1;
      if (dc_req_ready) state_d = S_WAIT;
    end else begin
      stall_out   = ~dc_resp_valid;
      wb_valid_d  = dc_resp_valid;
      wb_result_d = is_store ? '0 : load_data;
      if (dc_resp_valid) state_d = S_IDLE;
    end
    if (reset) begin
      dc_req_valid = 1'b0;
      stall_out    = 1'b0;
    end
  end
  // State and writeback record; pc/rob_id/result only move with a valid record
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wb_valid_q     <= 1'b0;
      wb_exception_q <= 1'b0;
      wb_result_q    <= '0;
      wb_pc_q        <= '0;
      wb_rob_id_q    <= '0;
    end else begin
      state_q        <= state_d;
      wb_valid_q     <= wb_valid_d;
      wb_exception_q <= wb_valid_d & wb_exception_d;
      if (wb_valid_d) begin
        wb_result_q <= wb_result_d;
        wb_pc_q     <= pc;
        wb_rob_id_q <= rob_id;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized self-checking bench with a transaction-level reference model
module tb_memory_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  instruction_type = '0;
  logic [31:0] pc = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] aluResult = '0;
  logic [31:0] s2 = '0;
  logic [3:0]  rob_id = '0;
  logic        valid = 1'b0;
  logic        stall_out, dc_req_valid, dc_we, wb_valid, wb_exception;
  logic        dc_req_ready = 1'b0;
  logic        dc_resp_valid = 1'b0;
  logic [31:0] dc_resp_data = '0;
  logic [31:0] dc_addr, dc_wdata, wb_pc, wb_result;
  logic [3:0]  dc_be, wb_rob_id;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  memory_stage dut (
    .clk(clk), .reset(reset), .instruction_type(instruction_type), .pc(pc), .funct3(funct3),
    .aluResult(aluResult), .s2(s2), .rob_id(rob_id), .valid(valid), .stall_out(stall_out),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_we(dc_we), .dc_addr(dc_addr),
    .dc_be(dc_be), .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_result(wb_result), .wb_rob_id(wb_rob_id),
    .wb_exception(wb_exception)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  // One instruction: held until the stage stops stalling, then one idle cycle where the record is checked
  task automatic run_op(input logic [1:0] t, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] s, input logic [31:0] rd, input int rdly, input int wdly,
                        input logic [31:0] pcv, input logic [3:0] robv);
    bit mem, st, bad, go;
    int ofs, nb, n;
    logic [31:0] ebe, ewd, eres, v, b, h;
    mem = (t == 2'd1) || (t == 2'd2);
    st = t == 2'd2;
    ofs = int'(a % 4);
    nb = 1 << f3[1:0];
    bad = mem && (f3 == 3 || f3 == 6 || f3 == 7 || (st && f3 > 3) || (ofs % nb) != 0);
    go = mem && !bad;
    ebe = ((32'd1 << nb) - 1) << ofs;
    ewd = s << (8 * ofs);
    v = rd >> (8 * ofs);
    b = v % 256;
    h = v % 65536;
    if (!go) eres = a;
    else if (st) eres = 0;
    else if (f3 == 0) eres = b >= 128 ? b - 256 : b;
    else if (f3 == 1) eres = h >= 32768 ? h - 65536 : h;
    else if (f3 == 4) eres = b;
    else if (f3 == 5) eres = h;
    else eres = v;
    n = go ? rdly + wdly + 2 : 1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        instruction_type = t; funct3 = f3; aluResult = a; s2 = s; pc = pcv; rob_id = robv; valid = 1'b1;
      end
      dc_req_ready = go ? (c == rdly) || (c > rdly && $urandom % 2 == 1) : 1'($urandom % 2);
      if (go) dc_resp_valid = c == n - 1 ? 1'b1 : c <= rdly ? 1'($urandom % 2) : 1'b0;
      else dc_resp_valid = 1'($urandom % 2);
      dc_resp_data = (go && c == n - 1) ? rd : $urandom;
      @(negedge clk);
      if (c == 0) check("wb_valid_idle", 32'(wb_valid), 0);
      check("stall_out", 32'(stall_out), 32'(c < n - 1 && go));
      check("dc_req_valid", 32'(dc_req_valid), 32'(go && c <= rdly));
      if (go && c <= rdly) begin
        check("dc_addr", dc_addr, a & 32'hFFFF_FFFC);
        check("dc_we", 32'(dc_we), 32'(st));
        if (st) begin
          check("dc_be", 32'(dc_be), ebe);
          check("dc_wdata", dc_wdata, ewd);
        end
      end
    end
    @(posedge clk); #1;
    valid = 1'b0; instruction_type = 2'($urandom); aluResult = $urandom; funct3 = 3'($urandom);
    dc_req_ready = 1'($urandom % 2); dc_resp_valid = 1'($urandom % 2); dc_resp_data = $urandom;
    @(negedge clk);
    check("wb_valid", 32'(wb_valid), 1);
    check("wb_result", wb_result, eres);
    check("wb_exception", 32'(wb_exception), 32'(bad));
    check("wb_pc", wb_pc, pcv);
    check("wb_rob_id", 32'(wb_rob_id), 32'(robv));
    @(posedge clk); #1 dc_resp_valid = 1'b0;
  endtask
  initial begin
    logic [1:0] t;
    logic [2:0] f3;
    logic [31:0] a;
    instruction_type = 2'd1; funct3 = 3'b010; aluResult = 32'h40; valid = 1'b1; dc_req_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_stall", 32'(stall_out), 0);
      check("rst_req", 32'(dc_req_valid), 0);
    end
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_result", wb_result, 0);
    check("rst_wb_pc", wb_pc, 0);
    check("rst_wb_rob", 32'(wb_rob_id), 0);
    check("rst_wb_exc", 32'(wb_exception), 0);
    @(posedge clk); #1 reset = 1'b0; valid = 1'b0;
    run_op(2'd0, 3'd0, 32'd7, 32'd0, 32'd0, 0, 0, 32'h1000, 4'd2);
    run_op(2'd1, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0, 32'h1004, 4'd3);
    run_op(2'd1, 3'b000, 32'h103, 32'd0, 32'h80000000, 0, 0, 32'h1008, 4'd4);
    run_op(2'd1, 3'b100, 32'h103, 32'd0, 32'h80000000, 0, 0, 32'h100C, 4'd5);
    run_op(2'd2, 3'b001, 32'h102, 32'h1234, 32'hFFFFFFFF, 3, 1, 32'h1010, 4'd6);
    run_op(2'd1, 3'b010, 32'h101, 32'd0, 32'd0, 0, 0, 32'h1014, 4'd7);
    run_op(2'd3, 3'b111, 32'h55, 32'd0, 32'd0, 0, 0, 32'h1018, 4'd8);
    run_op(2'd2, 3'b100, 32'h200, 32'd9, 32'd0, 0, 0, 32'h101C, 4'd9);
    run_op(2'd1, 3'b101, 32'h202, 32'd0, 32'h8001_7FFF, 1, 2, 32'h1020, 4'd10);
    // reset while the load sits in WAIT, then a stale response
    @(posedge clk); #1;
    instruction_type = 2'd1; funct3 = 3'b010; aluResult = 32'h300; pc = 32'h2000; rob_id = 4'd5;
    valid = 1'b1; dc_req_ready = 1'b1; dc_resp_valid = 1'b0;
    @(negedge clk);
    check("mid_req", 32'(dc_req_valid), 1);
    @(posedge clk); #1 reset = 1'b1; dc_req_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_stall", 32'(stall_out), 0);
    check("mid_rst_req", 32'(dc_req_valid), 0);
    @(posedge clk); #1 reset = 1'b0; valid = 1'b0; dc_resp_valid = 1'b1; dc_resp_data = 32'hCAFEF00D;
    @(negedge clk);
    check("mid_wb_valid", 32'(wb_valid), 0);
    check("mid_wb_result", wb_result, 0);
    check("mid_wb_pc", wb_pc, 0);
    check("mid_wb_rob", 32'(wb_rob_id), 0);
    check("mid_stall", 32'(stall_out), 0);
    @(posedge clk); #1 dc_resp_valid = 1'b0;
    @(negedge clk);
    check("stale_wb_valid", 32'(wb_valid), 0);
    run_op(2'd0, 3'd0, 32'hABCD, 32'd0, 32'd0, 0, 0, 32'h2004, 4'd1);
    for (int i = 0; i < 300; i++) begin
      t = 2'($urandom);
      f3 = $urandom % 4 == 0 ? 3'($urandom) : 3'($urandom % 3) | ((t == 2'd1 && $urandom % 2 == 1) ? 3'b100 : 3'b000);
      a = $urandom & ($urandom % 2 == 1 ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
      run_op(t, f3, a, $urandom, $urandom, int'($urandom % 4), int'($urandom % 4), $urandom, 4'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Memory (M) stage of the pipeline: consumes the instruction held in the execute-to-memory pipeline register, performs loads and stores against the data cache through a request/response handshake, and produces a registered writeback record (result, rob_id, exception) for the memory-to-writeback register. While a memory access is outstanding it holds the execute-to-memory register via `stall_out`. Non-memory instructions pass through with one cycle of latency.

## Interface
- `WORD_SIZE`, 32, datapath/address width
- `INSTR_TYPE_SZ`, `` `INSTR_TYPE_SZ`` (2), instruction-type field width
- `ROB_ENTRY_WIDTH`, `` `ROB_ENTRY_WIDTH``, ROB tag width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `instruction_type` in INSTR_TYPE_SZ: ALU=0, LOAD=1, STORE=2, other=3 (treated as ALU)
- `pc` in WORD_SIZE: instruction PC
- `funct3` in 3: access size/sign
- `aluResult` in WORD_SIZE: ALU result or effective address
- `s2` in WORD_SIZE: store data
- `rob_id` in ROB_ENTRY_WIDTH: ROB tag
- `valid` in 1: input instruction valid
- `stall_out` out 1: holds the execute-to-memory register
- `dc_req_valid` out 1, `dc_req_ready` in 1: cache request handshake
- `dc_we` out 1: 1=store
- `dc_addr` out WORD_SIZE: word-aligned address, bits [1:0]=0
- `dc_be` out 4: byte enables
- `dc_wdata` out WORD_SIZE: lane-shifted store data
- `dc_resp_valid` in 1, `dc_resp_data` in WORD_SIZE: cache response (full aligned word; data ignored for stores)
- `wb_valid`, `wb_pc`, `wb_result`, `wb_rob_id`, `wb_exception` out: registered writeback record

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, valid ALU: no request; next cycle wb_valid=1, wb_result=aluResult.
- IDLE, valid LOAD/STORE, aligned: dc_req_valid=1 combinationally. If dc_req_ready → WAIT, else → REQ.
- REQ: dc_req_valid=1 with the same fields. On dc_req_ready → WAIT.
- WAIT: on dc_resp_valid → IDLE. Next cycle wb_valid=1.
  - Load: wb_result = extracted lane.
  - Store: wb_result=0.
- Alignment: LB/LBU/SB any address; LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
- Misaligned access or undefined funct3 (011, 110, 111; or 1xx on a store):
  - no cache request, no stall;
  - next cycle wb_valid=1, wb_exception=1, wb_result=aluResult (faulting address).
- Load extraction from byte lane addr[1:0]:
  - LB (000) and LH (001) sign-extend;
  - LBU (100) and LHU (101) zero-extend;
  - LW (010) passes the word.
- Store: dc_be = 0001 / 0011 / 1111 shifted left by addr[1:0]; dc_wdata = s2 shifted left by 8·addr[1:0].
- Invalid input (valid=0) in IDLE: next cycle wb_valid=0, no request.
- wb_pc and wb_rob_id always track the instruction that generated the record.

## Timing
- `stall_out` = (IDLE ∧ valid ∧ aligned mem op) ∨ REQ ∨ (WAIT ∧ ¬dc_resp_valid).
  - It drops in the response cycle, so the upstream register advances on the same edge that completes the access.
- Latency:
  - ALU and exception: 1 cycle.
  - Memory access: request cycles + response wait + 1.
  - Minimum load latency is 2 cycles (ready in the issue cycle, response the next cycle).
- At most one outstanding request. dc_resp_valid outside WAIT is ignored.
- Request fields stay stable from the first dc_req_valid cycle until handshake completion.
- Reset:
  - FSM → IDLE; wb_valid=0, wb_exception=0, wb_result=0, wb_pc=0, wb_rob_id=0.
  - dc_req_valid=0 and stall_out=0 while reset=1.
  - A reset mid-access abandons it. A later stale response is ignored; the cache is reset by the same signal.

## Structure
- Shared package holds:
  - instruction-type encodings (ALU/LOAD/STORE);
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the FSM state enum.
- Sub-module `mem_align`: combinational misalignment check, load lane extract/extend, store be/wdata generation.
- Top level holds the FSM and the writeback register.

## Test plan
- ALU: type=0, aluResult=7, rob_id=2 → next cycle wb_valid=1, wb_result=7, wb_rob_id=2, stall_out=0 throughout.
- LW at 0x100, dc_req_ready=1, response 0xDEADBEEF one cycle later → dc_addr=0x100, dc_be=1111, stall_out high 1 cycle, wb_result=0xDEADBEEF.
- LB at 0x103, response 0x80000000 → wb_result=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102, s2=0x1234, dc_req_ready held low for 3 cycles:
  - dc_req_valid and fields stable for 4 cycles;
  - dc_be=1100, dc_wdata=0x12340000, dc_we=1;
  - stall_out high until the response.
- LW at 0x101 → no dc_req_valid, next cycle wb_exception=1, wb_result=0x101.
- Reset asserted while in WAIT, then dc_resp_valid arrives → all outputs zero, FSM IDLE, response ignored, no wb_valid.
